mips32_prog_loader: RTL

Program loader that fills the MIPS32 core's 1024×32 unified memory from a byte stream and holds the core in reset-halt until the image is complete. It accepts bytes over a valid/ready handshake and assembles big-endian 32-bit words. It writes them to consecutive word addresses through a single write port, then releases the core by deasserting `cpu_hold`. It is the writing end of the memory that the core's IF/MEM stages read.

---
 rtl/mips32_prog_loader_if.sv | 22 ++
 rtl/mips32_prog_loader.sv | 182 ++++++++++++++++++
 2 files changed

// File: rtl/mips32_prog_loader_if.sv
// Byte-stream input and memory write-port bundle of the MIPS32 program loader.
// slave = loader side, master = stream source / memory side.
interface mips32_prog_loader_if #(
   parameter int ADDR_W = 10
);
   logic              in_valid;
   logic [7:0]        in_data;
   logic              in_ready;
   logic              mem_we;
   logic [ADDR_W-1:0] mem_addr;
   logic [31:0]       mem_wdata;

   modport slave (
      input  in_valid, in_data,
      output in_ready, mem_we, mem_addr, mem_wdata
   );

   modport master (
      output in_valid, in_data,
      input  in_ready, mem_we, mem_addr, mem_wdata
   );
endinterface

// File: rtl/mips32_prog_loader.sv
// Loads a big-endian word image from a byte stream into the core's memory, holding the core
// until complete. Define LOADER_CHECKSUM_EN to require a trailing 32-bit XOR checksum word.
module mips32_prog_loader #(
   parameter int ADDR_W = 10
) (
   input  logic                 clk1,
   input  logic                 rst_n,
   input  logic                 start,
   mips32_prog_loader_if.slave  bus,
   output logic                 cpu_hold,
   output logic                 done,
   output logic                 error,
   output logic [ADDR_W:0]      words_loaded
);

   typedef enum logic [2:0] {
      S_HDR, S_DATA, S_DONE, S_ERR
`ifdef LOADER_CHECKSUM_EN
      , S_CSUM
`endif
   } state_e;

`ifdef LOADER_CHECKSUM_EN
   localparam state_e after_data_c = S_CSUM;
`else
   localparam state_e after_data_c = S_DONE;
`endif
   localparam logic [ADDR_W:0] one_c = 1;

   state_e            state_q, state_d;
   logic [1:0]        byte_cnt_q, byte_cnt_d;
   logic [31:0]       word_q, word_d;
   logic              word_valid_q, word_valid_d;
   logic [ADDR_W:0]   n_q, n_d;
   logic [ADDR_W:0]   cnt_q, cnt_d;
   logic              we_q, we_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [31:0]       wdata_q, wdata_d;
`ifdef LOADER_CHECKSUM_EN
   logic [31:0]       csum_q, csum_d;
`endif

   logic hdr_big, hdr_zero, phase_end, ready_state, ready, accept;

   assign hdr_big  = word_q > (32'd1 << ADDR_W);
   assign hdr_zero = word_q == 32'd0;

   // A completed word is acted on one cycle after its last byte; ready drops in that
   // cycle when the word ends the phase, so no byte of a following trailer slips in.
   always_comb begin
      phase_end   = 1'b0;
      ready_state = 1'b0;
      case (state_q)
         S_HDR: begin
            ready_state = 1'b1;
            phase_end   = word_valid_q && (hdr_big || hdr_zero);
         end
         S_DATA: begin
            ready_state = 1'b1;
            phase_end   = (cnt_q == n_q) || (word_valid_q && (cnt_q + one_c == n_q));
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            ready_state = 1'b1;
            phase_end   = word_valid_q;
         end
`endif
         default: ;
      endcase
      ready = ready_state && !start && !phase_end;
   end

   assign accept = bus.in_valid && ready;

   // NOTE: every variable written here gets a default first, otherwise a latch is inferred.
   always_comb begin
      state_d      = state_q;
      byte_cnt_d   = byte_cnt_q;
      word_d       = word_q;
      word_valid_d = 1'b0;
      n_d          = n_q;
      cnt_d        = cnt_q;
      we_d         = 1'b0;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
`ifdef LOADER_CHECKSUM_EN
      csum_d       = csum_q;
`endif

      if (accept) begin
         word_d       = {word_q[23:0], bus.in_data};
         byte_cnt_d   = byte_cnt_q + 2'd1;
         word_valid_d = (byte_cnt_q == 2'd3);
      end

      case (state_q)
         S_HDR: begin
            if (word_valid_q) begin
               if (hdr_big) begin
                  state_d = S_ERR;
               end else if (hdr_zero) begin
                  state_d = after_data_c;
               end else begin
                  n_d     = word_q[ADDR_W:0];
                  state_d = S_DATA;
               end
            end
         end
         S_DATA: begin
            if (word_valid_q) begin
               we_d    = 1'b1;
               addr_d  = cnt_q[ADDR_W-1:0];
               wdata_d = word_q;
               cnt_d   = cnt_q + one_c;
`ifdef LOADER_CHECKSUM_EN
               csum_d  = csum_q ^ word_q;
`endif
            end else if (cnt_q == n_q) begin
               state_d = after_data_c;
            end
         end
`ifdef LOADER_CHECKSUM_EN
         S_CSUM: begin
            if (word_valid_q) state_d = (word_q == csum_q) ? S_DONE : S_ERR;
         end
`endif
         default: ;
      endcase

      if (start) begin
         state_d      = S_HDR;
         byte_cnt_d   = 2'd0;
         word_valid_d = 1'b0;
         cnt_d        = '0;
         we_d         = 1'b0;
`ifdef LOADER_CHECKSUM_EN
         csum_d       = '0;
`endif
      end
   end

   // NOTE: state registers use non-blocking assignments so all of them update together.
   always_ff @(posedge clk1 or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= S_HDR;
         byte_cnt_q   <= 2'd0;
         word_q       <= '0;
         word_valid_q <= 1'b0;
         n_q          <= '0;
         cnt_q        <= '0;
         we_q         <= 1'b0;
         addr_q       <= '0;
         wdata_q      <= '0;
`ifdef LOADER_CHECKSUM_EN
         csum_q       <= '0;
`endif
      end else begin
         state_q      <= state_d;
         byte_cnt_q   <= byte_cnt_d;
         word_q       <= word_d;
         word_valid_q <= word_valid_d;
         n_q          <= n_d;
         cnt_q        <= cnt_d;
         we_q         <= we_d;
         addr_q       <= addr_d;
         wdata_q      <= wdata_d;
`ifdef LOADER_CHECKSUM_EN
         csum_q       <= csum_d;
`endif
      end
   end

   assign bus.in_ready  = ready;
   assign bus.mem_we    = we_q;
   assign bus.mem_addr  = addr_q;
   assign bus.mem_wdata = wdata_q;
   assign done          = (state_q == S_DONE);
   assign error         = (state_q == S_ERR);
   assign cpu_hold      = !done;
   assign words_loaded  = cnt_q;

endmodule
